prefetch_queue: RTL and testbench
=================================

# prefetch_queue

Instruction-byte producer for the w8086 decode stage. It issues 16-bit code fetches to the memory controller and buffers up to 6 bytes, in the style of the 8086 BIU queue. It presents the decoder with a 4-byte little-endian window, accepts a per-cycle consume count of 0–4 bytes, and restarts at a new CS:IP on a flush from the execution unit.

## Interface
- `QUEUE_DEPTH`, default 6: byte capacity of the queue.
- `RESET_CS`, default 16'hFFFF: CS after reset.
- `RESET_IP`, default 16'h0000: IP after reset.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard the queue and restart fetching at `flush_cs:flush_ip`.
- `flush_cs`  in  16  new code segment; sampled when `flush`=1.
- `flush_ip`  in  16  new instruction pointer; sampled when `flush`=1.
- `bus_req`  out  1  code-fetch request to the memory controller.
- `bus_addr`  out  20  physical fetch address, `{cs,4'b0} + fetch_ip` mod 2^20.
- `bus_byte`  out  1  1 = single-byte fetch (odd address), 0 = word fetch.
- `bus_ack`  in  1  fetch complete; `bus_data` valid this cycle.
- `bus_data`  in  16  fetched data; odd byte on [15:8], even byte on [7:0].
- `window`  out  32  queue bytes 0..3; byte 0 on [7:0]; invalid bytes driven 0.
- `window_count`  out  3  valid window bytes, `min(queue_count, 4)`.
- `queue_count`  out  3  bytes held, 0..QUEUE_DEPTH.
- `window_ip`  out  16  IP of window byte 0.
- `consume`  in  3  bytes retired by the decoder this cycle, 0..4.

## Operation
- **Reset:** queue empty. `cs=RESET_CS`. `fetch_ip=window_ip=RESET_IP`. FSM in IDLE. All outputs 0 except `window_ip`=RESET_IP.
- **FSM states:** IDLE, REQ, DISCARD.
- **IDLE → REQ** when neither `flush` nor a pending overflow blocks it, and the free space is enough for the next fetch:
  - `fetch_ip` even: free space (QUEUE_DEPTH − queue_count + consume) ≥ 2; issue a word fetch.
  - `fetch_ip` odd: free space ≥ 1; issue a byte fetch with `bus_byte`=1.
- **REQ:**
  - `bus_req`=1. `bus_addr` and `bus_byte` are held stable until `bus_ack`.
  - On `bus_ack`, write bytes to the tail:
    - Word fetch: [7:0] then [15:8]; `fetch_ip` += 2.
    - Byte fetch: [15:8] only; `fetch_ip` += 1.
  - Then go to IDLE.
- **DISCARD:** entered when `flush` arrives during REQ. A bus cycle cannot be aborted, so `bus_req` stays 1 until `bus_ack`. The returned data is dropped, then the FSM goes to IDLE.
- **Consume:**
  - Head advances by `consume`; `window_ip` += `consume` (16-bit wrap).
  - `consume` > `window_count` is clamped to `window_count`.
- **Flush:**
  - Takes priority over consume and over any ack-write in the same cycle.
  - Queue is emptied; `cs`, `fetch_ip` and `window_ip` load from `flush_*`.
  - Flush in IDLE or in the ack cycle of REQ goes to IDLE; otherwise REQ goes to DISCARD.
- **Simultaneous ack and consume:** both apply; new count = count − consume + written. The free-space check already guarantees no overflow.
- **Wrap-around:** `fetch_ip` 16'hFFFF + 1 → 16'h0000 with `cs` unchanged. The physical address wraps at 2^20.

## Timing
- `bus_req` is registered. It rises the cycle after IDLE sees sufficient space; the first request is at the first edge after `reset_n` deasserts.
- Fetch latency:
  - Ack at edge N: bytes are visible in `window`/`queue_count` after edge N.
  - Zero-wait-state memory (ack in the first REQ cycle) gives a minimum of 2 cycles per fetch.
- Consume at edge N: the shifted window is visible after edge N.
- Flush at edge N: `queue_count`=0 and `window_ip`=`flush_ip` after edge N. The new request starts no earlier than the cycle after N (from IDLE), or after the discarded ack.
- Reset mid-REQ: `bus_req` drops asynchronously. The memory controller is also reset, so no ack is expected.

## Structure
- Package `w8086_pkg`:
  - `fetch_state_t` enum (IDLE/REQ/DISCARD).
  - `RESET_CS`/`RESET_IP` constants.
  - `phys_addr(cs, ip)` function, shared with the memory controller.
- One sub-module, `byte_queue`: circular byte buffer with head/tail pointers mod QUEUE_DEPTH. It takes a 0–2 byte push and a 0–4 byte pop per cycle and exposes a 4-byte peek window.
- `prefetch_queue` holds the FSM, the IP/CS registers and the flush logic.

## Test plan
- **Reset fetch:** deassert reset; ack each request after 1 wait cycle with data 16'hB8_90 → first `bus_addr`=20'hFFFF0, `bus_byte`=0; window[15:0]=16'hB890.
- **Odd flush:** `flush_cs`=16'h1000, `flush_ip`=16'h0003 → single byte fetch at 20'h10003 with `bus_byte`=1, byte taken from [15:8]; next fetch is a word at 20'h10004.
- **Full queue:** no consume, zero-wait acks → exactly 3 word fetches; `queue_count`=6; `bus_req` stays 0 until `consume`≥2.
- **Ack + consume same cycle:** `queue_count`=4, ack of 2 bytes with `consume`=3 → `queue_count`=3; `window_ip` advances by 3.
- **Flush during wait state:** flush while REQ is waiting for ack → FSM in DISCARD; acked data dropped (`queue_count` stays 0); next `bus_addr` = new physical address.
- **Wrap:** `cs`=16'h0000, `fetch_ip`=16'hFFFE → word fetch at 20'h0FFFE, next at 20'h00000; `window_ip` wraps 16'hFFFF→16'h0000 on consume.

Source files
------------

// File: rtl/w8086_pkg.sv
// Shared w8086 types and helpers: fetch FSM states, reset CS:IP and the
// segment:offset to 20-bit physical address mapping used by all bus masters.
package w8086_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [15:0] RESET_CS = 16'hFFFF;
  localparam logic [15:0] RESET_IP = 16'h0000;

  // Physical address wraps at 1 MiB, exactly like the original part.
  function automatic logic [19:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 4'b0000} + {4'b0000, ip};
  endfunction

endpackage

// File: rtl/byte_queue.sv
// Circular byte buffer: 0-2 byte push and 0-4 byte pop per cycle, 4-byte peek window.
// Push/pop take effect at the clock edge; the caller guarantees no overflow or underflow.
module byte_queue #(
  parameter int DEPTH = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [1:0]  push_n_i,
  input  logic [15:0] push_dat_i,
  input  logic [2:0]  pop_n_i,
  output logic [31:0] window_o,
  output logic [2:0]  count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [2:0]    count_q, count_d;

  // Pointer advance modulo DEPTH; k never exceeds 4 and DEPTH is at least 4.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = ptr_add(head_q, int'(pop_n_i));
      tail_d  = ptr_add(tail_q, int'(push_n_i));
      count_d = count_q - pop_n_i + 3'(push_n_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i && (push_n_i != 2'd0)) mem_q[tail_q] <= push_dat_i[7:0];
    if (!clear_i && (push_n_i == 2'd2)) mem_q[ptr_add(tail_q, 1)] <= push_dat_i[15:8];
  end

  always_comb begin
    window_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(count_q)) window_o[8*i +: 8] = mem_q[ptr_add(head_q, i)];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// 8086-style code prefetcher: registered bus requests, >=2 cycles per fetch, 4-byte decode window.
// Fetches stall while the queue lacks room; an in-flight fetch is always completed, then dropped on flush.
module prefetch_queue #(
  parameter int          QUEUE_DEPTH = 6,
  parameter logic [15:0] RESET_CS    = w8086_pkg::RESET_CS,
  parameter logic [15:0] RESET_IP    = w8086_pkg::RESET_IP
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [15:0] flush_cs,
  input  logic [15:0] flush_ip,
  output logic        bus_req,
  output logic [19:0] bus_addr,
  output logic        bus_byte,
  input  logic        bus_ack,
  input  logic [15:0] bus_data,
  output logic [31:0] window,
  output logic [2:0]  window_count,
  output logic [2:0]  queue_count,
  output logic [15:0] window_ip,
  input  logic [2:0]  consume
);

  import w8086_pkg::*;

  fetch_state_t state_q, state_d;
  logic [15:0]  cs_q, cs_d;
  logic [15:0]  fetch_ip_q, fetch_ip_d;
  logic [15:0]  window_ip_q, window_ip_d;
  logic         bus_req_q, bus_req_d;
  logic [19:0]  bus_addr_q, bus_addr_d;
  logic         bus_byte_q, bus_byte_d;

  logic [2:0]   q_count;
  logic [31:0]  q_window;
  logic [2:0]   win_cnt;
  logic [2:0]   cons_eff;
  logic         room;
  logic         q_clear;
  logic [1:0]   push_n;
  logic [15:0]  push_dat;
  logic [2:0]   pop_n;

  byte_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .clear_i    (q_clear),
    .push_n_i   (push_n),
    .push_dat_i (push_dat),
    .pop_n_i    (pop_n),
    .window_o   (q_window),
    .count_o    (q_count)
  );

  assign win_cnt  = (q_count > 3'd4) ? 3'd4 : q_count;
  assign cons_eff = (consume > win_cnt) ? win_cnt : consume;

  // Space counts bytes the decoder frees this cycle; an odd IP needs only one byte.
  always_comb begin
    int free_space;
    free_space = QUEUE_DEPTH - int'(q_count) + int'(cons_eff);
    room       = fetch_ip_q[0] ? (free_space >= 1) : (free_space >= 2);
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    fetch_ip_d  = fetch_ip_q;
    window_ip_d = window_ip_q + 16'(cons_eff);
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_byte_d  = bus_byte_q;
    q_clear     = 1'b0;
    push_n      = 2'd0;
    push_dat    = 16'h0000;
    pop_n       = cons_eff;

    case (state_q)
      IDLE: begin
        if (!flush && room) begin
          state_d    = REQ;
          bus_req_d  = 1'b1;
          bus_addr_d = phys_addr(cs_q, fetch_ip_q);
          bus_byte_d = fetch_ip_q[0];
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (bus_byte_q) begin
            push_n     = 2'd1;
            push_dat   = {8'h00, bus_data[15:8]};
            fetch_ip_d = fetch_ip_q + 16'd1;
          end else begin
            push_n     = 2'd2;
            push_dat   = bus_data;
            fetch_ip_d = fetch_ip_q + 16'd2;
          end
        end
      end
      DISCARD: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    // Flush overrides any consume or ack-write; a bus cycle still open must drain in DISCARD.
    if (flush) begin
      q_clear     = 1'b1;
      push_n      = 2'd0;
      pop_n       = 3'd0;
      cs_d        = flush_cs;
      fetch_ip_d  = flush_ip;
      window_ip_d = flush_ip;
      if (state_q == REQ && !bus_ack) state_d = DISCARD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cs_q        <= RESET_CS;
      fetch_ip_q  <= RESET_IP;
      window_ip_q <= RESET_IP;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_byte_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      fetch_ip_q  <= fetch_ip_d;
      window_ip_q <= window_ip_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_byte_q  <= bus_byte_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_addr     = bus_addr_q;
  assign bus_byte     = bus_byte_q;
  assign window       = q_window;
  assign window_count = win_cnt;
  assign queue_count  = q_count;
  assign window_ip    = window_ip_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: hand-computed fetch addresses, window contents and counts.
module tb_prefetch_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [15:0] flush_cs;
  logic [15:0] flush_ip;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_byte;
  logic        bus_ack;
  logic [15:0] bus_data;
  logic [31:0] window;
  logic [2:0]  window_count;
  logic [2:0]  queue_count;
  logic [15:0] window_ip;
  logic [2:0]  consume;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  prefetch_queue dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .flush_cs     (flush_cs),
    .flush_ip     (flush_ip),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_byte     (bus_byte),
    .bus_ack      (bus_ack),
    .bus_data     (bus_data),
    .window       (window),
    .window_count (window_count),
    .queue_count  (queue_count),
    .window_ip    (window_ip),
    .consume      (consume)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [15:0] d);
    bus_ack  = 1'b1;
    bus_data = d;
    step();
    bus_ack  = 1'b0;
    bus_data = 16'h0000;
  endtask

  initial begin
    reset_n  = 1'b0;
    flush    = 1'b0;
    flush_cs = 16'h0000;
    flush_ip = 16'h0000;
    bus_ack  = 1'b0;
    bus_data = 16'h0000;
    consume  = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",  32'(bus_req), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_byte", 32'(bus_byte), 32'd0);
    chk("rst_win",  window, 32'd0);
    chk("rst_wcnt", 32'(window_count), 32'd0);
    chk("rst_qcnt", 32'(queue_count), 32'd0);
    chk("rst_wip",  32'(window_ip), 32'h0000);

    // Reset fetch, one wait state
    reset_n = 1'b1;
    step();
    chk("f0_req",  32'(bus_req), 32'd1);
    chk("f0_addr", 32'(bus_addr), 32'hFFFF0);
    chk("f0_byte", 32'(bus_byte), 32'd0);
    step();
    chk("f0_hold_req",  32'(bus_req), 32'd1);
    chk("f0_hold_addr", 32'(bus_addr), 32'hFFFF0);
    chk("f0_hold_qcnt", 32'(queue_count), 32'd0);
    ack(16'hB890);
    chk("f0_win",  window, 32'h0000B890);
    chk("f0_qcnt", 32'(queue_count), 32'd2);
    chk("f0_wcnt", 32'(window_count), 32'd2);
    chk("f0_idle", 32'(bus_req), 32'd0);

    // Fill the queue with zero-wait acks
    step();
    chk("f1_addr", 32'(bus_addr), 32'hFFFF2);
    chk("f1_req",  32'(bus_req), 32'd1);
    ack(16'h3322);
    chk("f1_qcnt", 32'(queue_count), 32'd4);
    chk("f1_win",  window, 32'h3322B890);
    step();
    chk("f2_addr", 32'(bus_addr), 32'hFFFF4);
    ack(16'h5544);
    chk("full_qcnt", 32'(queue_count), 32'd6);
    chk("full_wcnt", 32'(window_count), 32'd4);
    repeat (3) step();
    chk("full_noreq", 32'(bus_req), 32'd0);

    consume = 3'd1;
    step();
    consume = 3'd0;
    chk("c1_qcnt",  32'(queue_count), 32'd5);
    chk("c1_wip",   32'(window_ip), 32'h0001);
    chk("c1_win",   window, 32'h443322B8);
    chk("c1_noreq", 32'(bus_req), 32'd0);

    consume = 3'd2;
    step();
    consume = 3'd0;
    chk("c2_qcnt", 32'(queue_count), 32'd3);
    chk("c2_wip",  32'(window_ip), 32'h0003);
    chk("c2_win",  window, 32'h00554433);
    chk("c2_wcnt", 32'(window_count), 32'd3);
    chk("c2_req",  32'(bus_req), 32'd1);
    chk("c2_addr", 32'(bus_addr), 32'hFFFF6);

    // Ack and consume in the same cycle
    consume = 3'd1;
    ack(16'h7766);
    consume = 3'd0;
    chk("ac1_qcnt", 32'(queue_count), 32'd4);
    chk("ac1_wip",  32'(window_ip), 32'h0004);
    chk("ac1_win",  window, 32'h77665544);
    step();
    chk("ac2_req",  32'(bus_req), 32'd1);
    chk("ac2_addr", 32'(bus_addr), 32'hFFFF8);
    consume = 3'd3;
    ack(16'h9988);
    consume = 3'd0;
    chk("ac2_qcnt", 32'(queue_count), 32'd3);
    chk("ac2_wip",  32'(window_ip), 32'h0007);
    chk("ac2_win",  window, 32'h00998877);

    // Over-large consume is clamped to the window count
    consume = 3'd4;
    step();
    consume = 3'd0;
    chk("clamp_qcnt", 32'(queue_count), 32'd0);
    chk("clamp_wip",  32'(window_ip), 32'h000A);
    chk("clamp_win",  window, 32'd0);
    chk("clamp_req",  32'(bus_req), 32'd1);
    chk("clamp_addr", 32'(bus_addr), 32'hFFFFA);

    // Flush while the fetch is in a wait state
    flush    = 1'b1;
    flush_cs = 16'h1000;
    flush_ip = 16'h0003;
    step();
    flush = 1'b0;
    chk("disc_qcnt", 32'(queue_count), 32'd0);
    chk("disc_wip",  32'(window_ip), 32'h0003);
    chk("disc_req",  32'(bus_req), 32'd1);
    chk("disc_addr", 32'(bus_addr), 32'hFFFFA);
    ack(16'hDEAD);
    chk("disc_drop", 32'(queue_count), 32'd0);
    chk("disc_idle", 32'(bus_req), 32'd0);

    // Odd restart: byte fetch then word fetch
    step();
    chk("odd_req",  32'(bus_req), 32'd1);
    chk("odd_addr", 32'(bus_addr), 32'h10003);
    chk("odd_byte", 32'(bus_byte), 32'd1);
    ack(16'hAB12);
    chk("odd_qcnt", 32'(queue_count), 32'd1);
    chk("odd_win",  window, 32'h000000AB);
    chk("odd_wip",  32'(window_ip), 32'h0003);
    step();
    chk("even_addr", 32'(bus_addr), 32'h10004);
    chk("even_byte", 32'(bus_byte), 32'd0);
    ack(16'h2211);
    chk("even_win",  window, 32'h002211AB);

    // Flush in IDLE, then wrap of IP and physical address
    flush    = 1'b1;
    flush_cs = 16'h0000;
    flush_ip = 16'hFFFE;
    step();
    flush = 1'b0;
    chk("wf_qcnt",  32'(queue_count), 32'd0);
    chk("wf_wip",   32'(window_ip), 32'hFFFE);
    chk("wf_noreq", 32'(bus_req), 32'd0);
    step();
    chk("wr1_req",  32'(bus_req), 32'd1);
    chk("wr1_addr", 32'(bus_addr), 32'h0FFFE);
    ack(16'h3C4B);
    chk("wr1_win",  window, 32'h00003C4B);
    chk("wr1_qcnt", 32'(queue_count), 32'd2);
    step();
    chk("wr2_req",  32'(bus_req), 32'd1);
    chk("wr2_addr", 32'(bus_addr), 32'h00000);
    consume = 3'd1;
    step();
    chk("wr_wip1", 32'(window_ip), 32'hFFFF);
    chk("wr_win1", window, 32'h0000003C);
    step();
    consume = 3'd0;
    chk("wr_wip0", 32'(window_ip), 32'h0000);
    chk("wr_qcnt", 32'(queue_count), 32'd0);

    // Asynchronous reset while a request is outstanding
    chk("mid_req_pre", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_req_drop", 32'(bus_req), 32'd0);
    chk("mid_wip",      32'(window_ip), 32'h0000);
    chk("mid_addr",     32'(bus_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
